// File: rtl/mavg_pkg.sv
// Shared defaults, width helpers and FSM state encoding for the moving-average
// channel scheduler and its window bank.
package mavg_pkg;

  localparam int MAVG_NUM_CH   = 3;
  localparam int MAVG_SAMPLE_W = 2;
  localparam int MAVG_WINDOW   = 4;

  function automatic int sum_width(input int sample_w, input int window);
    return sample_w + $clog2(window);
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/mavg_window_bank.sv
// Per-channel sliding windows, running sums and fill counters behind a single
// write port; reports the post-update sum and full flag of the addressed channel.
module mavg_window_bank
  import mavg_pkg::*;
#(
  parameter int NUM_CH   = MAVG_NUM_CH,
  parameter int SAMPLE_W = MAVG_SAMPLE_W,
  parameter int WINDOW   = MAVG_WINDOW,
  parameter int SUM_W    = sum_width(SAMPLE_W, WINDOW),
  parameter int CH_W     = ch_width(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                clear,
  output logic [SUM_W-1:0]    upd_sum,
  output logic                upd_full
);

  localparam int FILL_W = $clog2(WINDOW) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WINDOW);

  // Index 0 holds the newest sample, index WINDOW-1 the oldest.
  logic [WINDOW-1:0][SAMPLE_W-1:0] win_q [NUM_CH];
  logic [WINDOW-1:0][SAMPLE_W-1:0] win_d [NUM_CH];
  logic [SUM_W-1:0]                sum_q [NUM_CH];
  logic [SUM_W-1:0]                sum_d [NUM_CH];
  logic [FILL_W-1:0]               fill_q [NUM_CH];
  logic [FILL_W-1:0]               fill_d [NUM_CH];
  logic [FILL_W-1:0]               upd_fill_s;
  logic [SAMPLE_W-1:0]             oldest_s;

  // Sum never underflows: the oldest sample is always part of the sum.
  always_comb begin
    oldest_s = win_q[wr_ch][WINDOW-1];
    upd_sum  = sum_q[wr_ch] + SUM_W'(wr_data) - SUM_W'(oldest_s);
    if (fill_q[wr_ch] == FILL_MAX) begin
      upd_fill_s = FILL_MAX;
    end else begin
      upd_fill_s = fill_q[wr_ch] + FILL_W'(1);
    end
    upd_full = (upd_fill_s == FILL_MAX);
  end

  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        win_d[c]  = '0;
        sum_d[c]  = '0;
        fill_d[c] = '0;
      end
    end else if (wr_en) begin
      win_d[wr_ch]  = {win_q[wr_ch][WINDOW-2:0], wr_data};
      sum_d[wr_ch]  = upd_sum;
      fill_d[wr_ch] = upd_fill_s;
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        win_q[c]  <= '0;
        sum_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/mavg_channel_scheduler.sv
// Round-robin scheduler sharing one moving-average window bank among NUM_CH
// sample sources. Define MAVG_ROUND_EN for a round-half-up average output.
module mavg_channel_scheduler
  import mavg_pkg::*;
#(
  parameter int NUM_CH   = MAVG_NUM_CH,
  parameter int SAMPLE_W = MAVG_SAMPLE_W,
  parameter int WINDOW   = MAVG_WINDOW,
  parameter int SUM_W    = sum_width(SAMPLE_W, WINDOW),
  parameter int CH_W     = ch_width(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] req_data,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_ch,
  output logic [SUM_W-1:0]           out_sum,
  output logic [SAMPLE_W-1:0]        out_avg,
  output logic                       out_full
);

  localparam int LOG_W = $clog2(WINDOW);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [SAMPLE_W-1:0] smp_q, smp_d;
  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic [SAMPLE_W-1:0] out_avg_q, out_avg_d;
  logic                out_full_q, out_full_d;

  logic [SAMPLE_W-1:0] req_smp_s [NUM_CH];
  logic [NUM_CH-1:0]   grant_s;
  logic [CH_W-1:0]     grant_ch_s;
  logic [SAMPLE_W-1:0] grant_data_s;
  logic                wr_en_s;
  logic                clear_s;
  logic [SUM_W-1:0]    upd_sum_s;
  logic                upd_full_s;
  logic [SUM_W-1:0]    shift_src_s;
  logic [SUM_W-1:0]    shifted_s;
  logic [SAMPLE_W-1:0] avg_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_split
    assign req_smp_s[g] = req_data[g*SAMPLE_W +: SAMPLE_W];
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    logic            found_v;
    logic [CH_W-1:0] cand_v;
    int              idx_v;
    grant_s      = '0;
    grant_ch_s   = '0;
    grant_data_s = '0;
    found_v      = 1'b0;
    cand_v       = '0;
    idx_v        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_v  = (int'(ptr_q) + i) % NUM_CH;
      cand_v = CH_W'(idx_v);
      if (!found_v && req_valid[cand_v]) begin
        found_v         = 1'b1;
        grant_s[cand_v] = 1'b1;
        grant_ch_s      = cand_v;
        grant_data_s    = req_smp_s[cand_v];
      end else begin
        found_v = found_v;
      end
    end
  end

  always_comb begin
    if (rst_n && !flush && (state_q == IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
`ifdef MAVG_ROUND_EN
    shift_src_s = upd_sum_s + SUM_W'(WINDOW / 2);
`else
    shift_src_s = upd_sum_s;
`endif
    shifted_s = shift_src_s >> LOG_W;
    avg_s     = shifted_s[SAMPLE_W-1:0];
  end

  // Flush overrides every state: clear the bank and drop any pending result.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    smp_d       = smp_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_sum_d   = out_sum_q;
    out_avg_d   = out_avg_q;
    out_full_d  = out_full_q;
    wr_en_s     = 1'b0;
    clear_s     = 1'b0;
    if (flush) begin
      clear_s     = 1'b1;
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            smp_d   = grant_data_s;
            ch_d    = grant_ch_s;
            ptr_d   = grant_ch_s;
            state_d = UPDATE;
          end else begin
            state_d = IDLE;
          end
        end
        UPDATE: begin
          wr_en_s     = 1'b1;
          out_sum_d   = upd_sum_s;
          out_avg_d   = avg_s;
          out_full_d  = upd_full_s;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = EMIT;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= CH_W'(NUM_CH - 1);
      ch_q        <= '0;
      smp_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= '0;
      out_avg_q   <= '0;
      out_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      smp_q       <= smp_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_sum_q   <= out_sum_d;
      out_avg_q   <= out_avg_d;
      out_full_q  <= out_full_d;
    end
  end

  mavg_window_bank #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .WINDOW   (WINDOW),
    .SUM_W    (SUM_W),
    .CH_W     (CH_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en_s),
    .wr_ch    (ch_q),
    .wr_data  (smp_q),
    .clear    (clear_s),
    .upd_sum  (upd_sum_s),
    .upd_full (upd_full_s)
  );

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_sum   = out_sum_q;
  assign out_avg   = out_avg_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_mavg_channel_scheduler.sv
// Directed bench for mavg_channel_scheduler at default parameters; expected
// averages follow MAVG_ROUND_EN when it is defined.
module tb_mavg_channel_scheduler;

`ifdef MAVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_valid;
  logic [5:0] req_data;
  logic [2:0] req_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [3:0] out_sum;
  logic [1:0] out_avg;
  logic       out_full;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int xfer_cyc = 0;
  int prev_cyc = 0;

  mavg_channel_scheduler #(
    .NUM_CH   (3),
    .SAMPLE_W (2),
    .WINDOW   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_full  (out_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick_avg(input int avg_trunc, input int avg_round);
    return ROUND ? avg_round : avg_trunc;
  endfunction

  task automatic finish_xfer();
    int n;
    req_valid = 3'b000;
    xfer_cyc  = cyc;
    @(negedge clk);
    chk("update_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid !== 1'b1) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic xfer(input logic [2:0] mask, input logic [5:0] data, input logic [2:0] exp_grant);
    req_valid = mask;
    req_data  = data;
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(exp_grant));
    @(posedge clk); #1;
    finish_xfer();
  endtask

  task automatic expect_out(input int ch, input int sum, input int avg_t, input int avg_r, input int full);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_ch", 32'(out_ch), 32'(ch));
    chk("out_sum", 32'(out_sum), 32'(sum));
    chk("out_avg", 32'(out_avg), 32'(pick_avg(avg_t, avg_r)));
    chk("out_full", 32'(out_full), 32'(full));
  endtask

  task automatic handshake();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] mask, input logic [5:0] data, input logic [2:0] exp_grant,
                      input int ch, input int sum, input int avg_t, input int avg_r, input int full);
    xfer(mask, data, exp_grant);
    expect_out(ch, sum, avg_t, avg_r, full);
    handshake();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_data  = 6'b10_01_11;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset held two cycles with all channels requesting
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_avg", 32'(out_avg), 32'd0);
    chk("rst_out_full", 32'(out_full), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill ch0 with 3,3,3,3 (first grant after reset must be ch0)
    send(3'b111, 6'b10_01_11, 3'b001, 0, 3, 0, 1, 0);
    send(3'b001, 6'b00_00_11, 3'b001, 0, 6, 1, 2, 0);
    send(3'b001, 6'b00_00_11, 3'b001, 0, 9, 2, 2, 0);
    send(3'b001, 6'b00_00_11, 3'b001, 0, 12, 3, 3, 1);

    // Slide ch0 with 0 then 1
    send(3'b001, 6'b00_00_00, 3'b001, 0, 9, 2, 2, 1);
    send(3'b001, 6'b00_00_01, 3'b001, 0, 7, 1, 2, 1);

    // Reset again: clears sums and restores ptr so ch0 wins first
    rst_n     = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    chk("rst2_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_out_sum", 32'(out_sum), 32'd0);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_first_grant", 32'(req_ready), 32'd1);
    req_valid = 3'b000;
    @(posedge clk); #1;

    // Round-robin with all channels requesting: ch0=2, ch1=1, ch2=3
    send(3'b111, 6'b11_01_10, 3'b001, 0, 2, 0, 1, 0);
    prev_cyc = xfer_cyc;
    send(3'b111, 6'b11_01_10, 3'b010, 1, 1, 0, 0, 0);
    chk("rr_gap_1", 32'(xfer_cyc - prev_cyc), 32'd3);
    prev_cyc = xfer_cyc;
    send(3'b111, 6'b11_01_10, 3'b100, 2, 3, 0, 1, 0);
    chk("rr_gap_2", 32'(xfer_cyc - prev_cyc), 32'd3);
    prev_cyc = xfer_cyc;
    send(3'b111, 6'b11_01_10, 3'b001, 0, 4, 1, 1, 0);
    chk("rr_gap_3", 32'(xfer_cyc - prev_cyc), 32'd3);

    // Backpressure: ch1 sends 2 (sum 1 -> 3) with out_ready low for 5 cycles
    out_ready = 1'b0;
    xfer(3'b010, 6'b00_10_00, 3'b010);
    expect_out(1, 3, 0, 1, 0);
    req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'd3);
      chk("bp_ch", 32'(out_ch), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'd4);
    req_valid = 3'b000;
    @(posedge clk); #1;

    // Flush coincident with a ch0 request in IDLE: no grant, bank cleared
    req_valid = 3'b001;
    req_data  = 6'b00_00_11;
    flush     = 1'b1;
    @(negedge clk);
    chk("flush_idle_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_still_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    finish_xfer();
    expect_out(0, 3, 0, 1, 0);
    handshake();
    send(3'b001, 6'b00_00_11, 3'b001, 0, 6, 1, 2, 0);

    // Flush during UPDATE of a third ch0 sample
    req_valid = 3'b001;
    req_data  = 6'b00_00_11;
    @(negedge clk);
    chk("flush_upd_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 3'b000;
    flush     = 1'b1;
    @(negedge clk);
    chk("flush_upd_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 3'b001;
    req_data  = 6'b00_00_10;
    @(negedge clk);
    chk("flush_dropped_valid", 32'(out_valid), 32'd0);
    chk("flush_idle_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    finish_xfer();
    expect_out(0, 2, 0, 1, 0);
    handshake();
    @(negedge clk);
    chk("final_idle_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
